cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

Consumer side of the ALU flag interface in the single-cycle ARM datapath. Holds the architectural NZCV flags, updates them from the ALU's Negative/Zero/CarryOut/overflow outputs under per-group write enables, and evaluates each instruction's 4-bit condition field against the stored flags. Decoder control strobes (PCSrc, RegWrite, MemWrite) pass only when the condition holds. Saturating executed/squashed instruction counters are provided for debug.

## Interface

- CNT_W, 16, width of each instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- instr_valid  in  1  an instruction is present this cycle
- cond  in  4  ARM condition field, instr[31:28]
- flag_write  in  2  bit1 = update N,Z; bit0 = update C,V (S-bit and op-class qualified by decoder)
- alu_negative, alu_zero, alu_carry, alu_overflow  in  1 each  ALU flag outputs for the current instruction
- pcs_in, reg_write_in, mem_write_in  in  1 each  unqualified decoder strobes
- no_write_in  in  1  compare-class op (CMP/CMN/TST/TEQ): suppress reg_write even if cond passes
- cnt_clear  in  1  synchronous clear of both counters
- pcs, reg_write, mem_write  out  1 each  qualified strobes
- cond_ex  out  1  condition passed, instr_valid high
- flags  out  4  stored {N,Z,C,V}
- exec_count  out  CNT_W  instructions with cond_ex = 1
- skip_count  out  CNT_W  instructions with instr_valid = 1, cond_ex = 0

## Operation

- Condition evaluation uses the registered flags only, never the current ALU flags.
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V)
  - AL 1110 1; 1111 reserved, evaluates 0 (squashed, counted in skip_count)
- cond_ex = instr_valid & pass.
- Strobe gating:
  - pcs = pcs_in & cond_ex
  - mem_write = mem_write_in & cond_ex
  - reg_write = reg_write_in & cond_ex & !no_write_in
- Flag update at the rising edge:
  - N,Z <= alu_negative, alu_zero when cond_ex & flag_write[1]
  - C,V <= alu_carry, alu_overflow when cond_ex & flag_write[0]
  - Groups are independent; a logical op with S set writes NZ only and leaves CV unchanged.
  - A squashed instruction never writes flags.
- Counters:
  - exec_count += 1 on cond_ex; skip_count += 1 on instr_valid & !cond_ex.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clear has priority: an increment in the same cycle is dropped, result is 0.

## Timing

- Reset (async assert, sync-to-clk deassert by system): flags = 0000, exec_count = 0, skip_count = 0. pcs/reg_write/mem_write then follow inputs combinationally; with flags 0000, EQ fails and NE passes.
- Strobes and cond_ex: combinational, zero latency from cond, instr_valid, strobes, and flags.
- flags: one-cycle latency. Instruction k's flag write is visible to instruction k+1's condition in the next cycle.
- Flag-setting instruction whose own cond depends on flags: evaluated on pre-update flags, then updates. Example: ADDSEQ with Z=1 passes and writes the new Z.
- Reset mid-run: flags and counters clear immediately, independent of clk. No partial update is retained.
- instr_valid = 0: all outputs except flags and counters are 0; no state changes except cnt_clear.

## Structure

- Shared package cpu_pkg:
  - COND_EQ … COND_NV 4-bit localparams
  - flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0
  - FW_NZ / FW_CV bit positions of flag_write
- Sub-module cond_check: purely combinational (cond, flags) -> pass. Reused by any future branch predictor.
- Top level holds the flag register, strobe gating, and two saturating counters (one counter template instantiated twice is acceptable).

## Test plan

- Reset, then cond = 0000 (EQ), instr_valid = 1, reg_write_in = 1 -> cond_ex = 0, reg_write = 0, skip_count = 1, flags = 0000.
- SUBS-like: flag_write = 11, cond = 1110, ALU N=0 Z=1 C=1 V=0 -> next cycle flags = 0110. Then cond = 0000 with mem_write_in = 1 -> mem_write = 1; cond = 1000 (HI) -> cond_ex = 0.
- flags = 1001, flag_write = 10, ALU N=0 Z=0 C=1 V=1 -> flags = 0001 (CV held). Then GE (1010) fails, LT (1011) passes.
- CMP: no_write_in = 1, reg_write_in = 1, cond = 1110 -> reg_write = 0, flags updated, exec_count increments.
- Set CNT_W = 4 and issue 17 passing instructions -> exec_count holds at 15. Assert cnt_clear with instr_valid = 1 in the same cycle -> exec_count = 0.
- Assert rst_n low between clock edges while flags = 1111 -> flags = 0000 before the next edge. cond = 1111 -> never passes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Provides ARM condition-field encodings, NZCV bit positions within the
// stored flag vector, and bit positions of the decoder's flag_write field.
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Positions within the stored {N,Z,C,V} vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Positions within flag_write
  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator.
// Ports:
//   i_cond  - 4-bit condition field
//   i_flags - stored {N,Z,C,V}
//   o_pass  - condition holds (reserved encoding 1111 never passes)
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    unique case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   i_clear    - synchronous clear, wins over i_inc
//   i_inc      - increment request, ignored once the counter is all ones
//   o_count    - current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV flag holder and condition-execution gate.
// Conditions are evaluated on the stored flags only; the ALU flags of the
// current instruction are written (per NZ / CV group) at the next edge when
// the instruction executes. Decoder strobes are gated by cond_ex.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   instr_valid, cond             - instruction present, condition field
//   flag_write                    - [1] update N,Z  [0] update C,V
//   alu_negative/zero/carry/overflow - ALU flag results
//   pcs_in, reg_write_in, mem_write_in - unqualified decoder strobes
//   no_write_in                   - compare-class op, suppress reg_write
//   cnt_clear                     - synchronous clear of both counters
//   pcs, reg_write, mem_write     - qualified strobes
//   cond_ex                       - instruction executes
//   flags                         - stored {N,Z,C,V}
//   exec_count, skip_count        - saturating executed / squashed counts
module cond_flag_unit
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [3:0]       cond,
  input  logic [1:0]       flag_write,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             pcs_in,
  input  logic             reg_write_in,
  input  logic             mem_write_in,
  input  logic             no_write_in,
  input  logic             cnt_clear,
  output logic             pcs,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
);

  logic [3:0] r_flags;
  logic       w_pass;
  logic       w_cond_ex;
  logic       w_skip;

  cond_check u_cond_check (
    .i_cond  (cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  assign w_cond_ex = instr_valid & w_pass;
  assign w_skip    = instr_valid & ~w_pass;

  assign cond_ex   = w_cond_ex;
  assign pcs       = pcs_in & w_cond_ex;
  assign mem_write = mem_write_in & w_cond_ex;
  assign reg_write = reg_write_in & w_cond_ex & ~no_write_in;
  assign flags     = r_flags;

  // NZ and CV groups update independently so logical ops leave C,V intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else begin
      if (w_cond_ex && flag_write[FW_NZ]) begin
        r_flags[FLAG_N] <= alu_negative;
        r_flags[FLAG_Z] <= alu_zero;
      end
      if (w_cond_ex && flag_write[FW_CV]) begin
        r_flags[FLAG_C] <= alu_carry;
        r_flags[FLAG_V] <= alu_overflow;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_exec_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (cnt_clear),
    .i_inc   (w_cond_ex),
    .o_count (exec_count)
  );

  sat_counter #(.W(CNT_W)) u_skip_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (cnt_clear),
    .i_inc   (w_skip),
    .o_count (skip_count)
  );

endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic             clk;
  logic             rst_n;
  logic             instr_valid;
  logic [3:0]       cond;
  logic [1:0]       flag_write;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_overflow;
  logic             pcs_in;
  logic             reg_write_in;
  logic             mem_write_in;
  logic             no_write_in;
  logic             cnt_clear;
  logic             pcs;
  logic             reg_write;
  logic             mem_write;
  logic             cond_ex;
  logic [3:0]       flags;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] skip_count;

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .cond         (cond),
    .flag_write   (flag_write),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .pcs_in       (pcs_in),
    .reg_write_in (reg_write_in),
    .mem_write_in (mem_write_in),
    .no_write_in  (no_write_in),
    .cnt_clear    (cnt_clear),
    .pcs          (pcs),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .cond_ex      (cond_ex),
    .flags        (flags),
    .exec_count   (exec_count),
    .skip_count   (skip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic cond_ex;
    logic pcs;
    logic reg_write;
    logic mem_write;
  } exp_t;

  exp_t q_exp[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_flags;
  int         m_exec;
  int         m_skip;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Conditions come in pass/complement pairs; bit 0 inverts the base test.
  function automatic logic m_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // One instruction slot: drive at negedge, check combinational outputs
  // before the rising edge, then check registered state after it.
  task automatic issue(input string tag, input logic v, input logic [3:0] c,
                       input logic [1:0] fw, input logic [3:0] alu,
                       input logic p, input logic rw, input logic mw,
                       input logic nw, input logic clr);
    exp_t e, o;
    logic pass;
    @(negedge clk);
    instr_valid = v; cond = c; flag_write = fw;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = alu;
    pcs_in = p; reg_write_in = rw; mem_write_in = mw;
    no_write_in = nw; cnt_clear = clr;
    pass = v && m_pass(c, m_flags);
    e.cond_ex   = pass;
    e.pcs       = p && pass;
    e.reg_write = rw && pass && !nw;
    e.mem_write = mw && pass;
    q_exp.push_back(e);
    #1;
    if (q_exp.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      o = q_exp.pop_front();
      check({tag, "_cond_ex"},   cond_ex,   o.cond_ex);
      check({tag, "_pcs"},       pcs,       o.pcs);
      check({tag, "_reg_write"}, reg_write, o.reg_write);
      check({tag, "_mem_write"}, mem_write, o.mem_write);
    end
    @(posedge clk);
    if (pass && fw[1]) m_flags[3:2] = alu[3:2];
    if (pass && fw[0]) m_flags[1:0] = alu[1:0];
    if (clr) begin
      m_exec = 0; m_skip = 0;
    end else begin
      if (pass && m_exec < CNT_MAX) m_exec++;
      if (v && !pass && m_skip < CNT_MAX) m_skip++;
    end
    #1;
    check({tag, "_flags"}, flags,      m_flags);
    check({tag, "_exec"},  exec_count, m_exec);
    check({tag, "_skip"},  skip_count, m_skip);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 0; cond = '0; flag_write = '0;
    alu_negative = 0; alu_zero = 0; alu_carry = 0; alu_overflow = 0;
    pcs_in = 0; reg_write_in = 0; mem_write_in = 0; no_write_in = 0; cnt_clear = 0;
    m_flags = '0; m_exec = 0; m_skip = 0;

    #3;
    check("rst_flags", flags, 4'b0000);
    check("rst_exec",  exec_count, 0);
    check("rst_skip",  skip_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // EQ fails on cleared flags
    issue("eq_after_rst", 1, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 0, 0);
    check("eq_skip1", skip_count, 1);
    // NE passes on cleared flags
    issue("ne_after_rst", 1, 4'b0001, 2'b00, 4'b0000, 1, 1, 1, 0, 0);

    // SUBS-like: NZCV <= 0110
    issue("subs", 1, 4'b1110, 2'b11, 4'b0110, 0, 1, 0, 0, 0);
    check("subs_flags", flags, 4'b0110);
    issue("eq_mw",  1, 4'b0000, 2'b00, 4'b0000, 0, 0, 1, 0, 0);
    issue("hi_z1",  1, 4'b1000, 2'b00, 4'b0000, 1, 1, 1, 0, 0);

    // NZ-only update holds C,V
    issue("set1001", 1, 4'b1110, 2'b11, 4'b1001, 0, 0, 0, 0, 0);
    issue("nz_only", 1, 4'b1110, 2'b10, 4'b0011, 0, 1, 0, 0, 0);
    check("nz_only_flags", flags, 4'b0001);
    issue("ge_fail", 1, 4'b1010, 2'b00, 4'b0000, 1, 1, 1, 0, 0);
    issue("lt_pass", 1, 4'b1011, 2'b00, 4'b0000, 1, 1, 1, 0, 0);

    // CMP: reg_write suppressed, flags still written
    issue("cmp", 1, 4'b1110, 2'b11, 4'b0100, 1, 1, 1, 1, 0);
    // ADDSEQ on Z=1: passes on old flags, clears Z
    issue("addseq", 1, 4'b0000, 2'b11, 4'b0000, 0, 1, 0, 0, 0);
    issue("eq_after_addseq", 1, 4'b0000, 2'b00, 4'b0000, 1, 1, 1, 0, 0);
    // Squashed instruction must not write flags
    issue("squash_nowrite", 1, 4'b0000, 2'b11, 4'b1111, 1, 1, 1, 0, 0);
    // instr_valid low gates everything
    issue("invalid", 0, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0, 0);

    // Sweep all conditions over several flag states
    for (int k = 0; k < 6; k++) begin
      logic [3:0] fv;
      fv = (k < 4) ? 4'(k * 5) : 4'($urandom_range(0, 15));
      issue("setf", 1, 4'b1110, 2'b11, fv, 0, 0, 0, 0, 0);
      for (int c = 0; c < 16; c++) begin
        issue("sweep", 1, 4'(c), 2'b00, 4'b0000, 1, 1, 1, 0, 0);
      end
    end

    // Saturation and clear priority
    issue("clr", 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      issue("sat", 1, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
    end
    check("sat_hold", exec_count, 15);
    issue("clr_vs_inc", 1, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
    check("clr_result", exec_count, 0);

    // Asynchronous reset between edges with flags = 1111
    issue("set1111", 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 0, 0, 0);
    issue("skip_one", 1, 4'b1111, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    instr_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    m_flags = '0; m_exec = 0; m_skip = 0;
    check("async_rst_flags", flags, 4'b0000);
    check("async_rst_exec",  exec_count, 0);
    check("async_rst_skip",  skip_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reserved NV never passes
    issue("nv0", 1, 4'b1111, 2'b11, 4'b1111, 1, 1, 1, 0, 0);
    issue("set_all", 1, 4'b1110, 2'b11, 4'b1111, 0, 0, 0, 0, 0);
    issue("nv1", 1, 4'b1111, 2'b11, 4'b0000, 1, 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
